// File: rtl/exception_sequencer.sv
// Exception sequencer: saves EPC, fetches the vector byte for the
// cause and loads PC from the zero-extended byte.
module exception_sequencer #(
  parameter int          MEM_LATENCY  = 2,
  parameter logic [31:0] VEC_OPCODE   = 32'd253,
  parameter logic [31:0] VEC_OVERFLOW = 32'd254,
  parameter logic [31:0] VEC_DIV0     = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  output logic        busy,
  output logic        epc_write,
  output logic        mem_addr_sel,
  output logic [31:0] exc_addr,
  output logic        mem_read,
  output logic        ext_sel,
  output logic        pc_write,
  output logic        pc_src_exc,
  output logic        exc_done,
  output logic [1:0]  exc_cause
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_FETCH,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_cause;
  logic [31:0] r_addr;
  logic        w_any;

  assign w_any = exc_opcode | exc_overflow | exc_div0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_cause <= 2'b00;
      r_addr  <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_SAVE;
            r_cnt   <= CNT_INIT;
            // opcode outranks overflow, which outranks div0
            if (exc_opcode) begin
              r_cause <= 2'b01;
              r_addr  <= VEC_OPCODE;
            end else if (exc_overflow) begin
              r_cause <= 2'b10;
              r_addr  <= VEC_OVERFLOW;
            end else begin
              r_cause <= 2'b11;
              r_addr  <= VEC_DIV0;
            end
          end
        end
        S_SAVE:  r_state <= S_FETCH;
        S_FETCH: begin
          if (r_cnt == 4'd0) r_state <= S_LOAD;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_LOAD:  r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign epc_write    = (r_state == S_SAVE);
  assign mem_addr_sel = (r_state == S_FETCH) | (r_state == S_LOAD);
  assign mem_read     = (r_state == S_FETCH);
  assign ext_sel      = (r_state == S_FETCH) | (r_state == S_LOAD);
  assign pc_write     = (r_state == S_LOAD);
  assign pc_src_exc   = (r_state == S_LOAD);
  assign exc_done     = (r_state == S_DONE);
  assign exc_addr     = r_addr;
  assign exc_cause    = r_cause;

endmodule

// File: tb/tb_exception_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_exception_sequencer;

  logic        clk;
  logic        reset;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic        busy;
  logic        epc_write;
  logic        mem_addr_sel;
  logic [31:0] exc_addr;
  logic        mem_read;
  logic        ext_sel;
  logic        pc_write;
  logic        pc_src_exc;
  logic        exc_done;
  logic [1:0]  exc_cause;

  exception_sequencer #(.MEM_LATENCY(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .busy         (busy),
    .epc_write    (epc_write),
    .mem_addr_sel (mem_addr_sel),
    .exc_addr     (exc_addr),
    .mem_read     (mem_read),
    .ext_sel      (ext_sel),
    .pc_write     (pc_write),
    .pc_src_exc   (pc_src_exc),
    .exc_done     (exc_done),
    .exc_cause    (exc_cause)
  );

  // strobes: {busy,epc_write,mem_addr_sel,mem_read,ext_sel,pc_write,pc_src_exc,exc_done}
  localparam logic [7:0] ST_IDLE  = 8'b0000_0000;
  localparam logic [7:0] ST_SAVE  = 8'b1100_0000;
  localparam logic [7:0] ST_FETCH = 8'b1011_1000;
  localparam logic [7:0] ST_LOAD  = 8'b1010_1110;
  localparam logic [7:0] ST_DONE  = 8'b1000_0001;

  typedef struct {
    int          cyc;
    string       name;
    logic [7:0]  s;
    logic [1:0]  c;
    logic [31:0] a;
  } ent_t;

  ent_t q[$];
  int   cyc;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    logic [7:0] act;
    ent_t e;
    act = {busy, epc_write, mem_addr_sel, mem_read,
           ext_sel, pc_write, pc_src_exc, exc_done};
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks = checks + 1;
      if (e.cyc != cyc || act !== e.s || exc_cause !== e.c
          || exc_addr !== e.a) begin
        errors = errors + 1;
        $display("FAIL %s cyc=%0d: got strb=%b cause=%b addr=%0d, want strb=%b cause=%b addr=%0d (for cyc %0d)",
                 e.name, cyc, act, exc_cause, exc_addr,
                 e.s, e.c, e.a, e.cyc);
      end
    end
  end

  // inputs apply to the cycle after the next edge; expectation is
  // for the cycle after the edge that samples them
  task automatic step(input string nm, input logic r, input logic op,
                      input logic ov, input logic dz,
                      input logic [7:0] s, input logic [1:0] c,
                      input logic [31:0] a);
    ent_t e;
    @(posedge clk);
    #1;
    reset        = r;
    exc_opcode   = op;
    exc_overflow = ov;
    exc_div0     = dz;
    e.cyc  = cyc + 1;
    e.name = nm;
    e.s    = s;
    e.c    = c;
    e.a    = a;
    q.push_back(e);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    exc_opcode   = 1'b0;
    exc_overflow = 1'b0;
    exc_div0     = 1'b0;

    // 1: reset held two cycles
    step("rst0", 1, 0, 0, 0, ST_IDLE, 2'b00, 32'd0);
    step("rst1", 1, 0, 0, 0, ST_IDLE, 2'b00, 32'd0);
    step("idle", 0, 0, 0, 0, ST_IDLE, 2'b00, 32'd0);

    // 2: invalid opcode
    step("op_save",  0, 1, 0, 0, ST_SAVE,  2'b01, 32'd253);
    step("op_f1",    0, 0, 0, 0, ST_FETCH, 2'b01, 32'd253);
    step("op_f2",    0, 0, 0, 0, ST_FETCH, 2'b01, 32'd253);
    step("op_load",  0, 0, 0, 0, ST_LOAD,  2'b01, 32'd253);
    step("op_done",  0, 0, 0, 0, ST_DONE,  2'b01, 32'd253);
    step("op_idle",  0, 0, 0, 0, ST_IDLE,  2'b01, 32'd253);

    // 3: overflow and div0 together, overflow wins
    step("ov_save",  0, 0, 1, 1, ST_SAVE,  2'b10, 32'd254);
    step("ov_f1",    0, 0, 0, 0, ST_FETCH, 2'b10, 32'd254);
    step("ov_f2",    0, 0, 0, 0, ST_FETCH, 2'b10, 32'd254);
    step("ov_load",  0, 0, 0, 0, ST_LOAD,  2'b10, 32'd254);
    step("ov_done",  0, 0, 0, 0, ST_DONE,  2'b10, 32'd254);
    step("ov_idle",  0, 0, 0, 0, ST_IDLE,  2'b10, 32'd254);
    step("ov_idle2", 0, 0, 0, 0, ST_IDLE,  2'b10, 32'd254);

    // 4: div0, opcode pulse during FETCH_VEC ignored
    step("dz_save",  0, 0, 0, 1, ST_SAVE,  2'b11, 32'd255);
    step("dz_f1",    0, 0, 0, 0, ST_FETCH, 2'b11, 32'd255);
    step("dz_f2",    0, 1, 0, 0, ST_FETCH, 2'b11, 32'd255);
    step("dz_load",  0, 0, 0, 0, ST_LOAD,  2'b11, 32'd255);
    step("dz_done",  0, 0, 0, 0, ST_DONE,  2'b11, 32'd255);
    step("dz_idle",  0, 0, 0, 0, ST_IDLE,  2'b11, 32'd255);
    step("dz_idle2", 0, 0, 0, 0, ST_IDLE,  2'b11, 32'd255);

    // 5: reset in second FETCH_VEC cycle
    step("mr_save",  0, 0, 1, 0, ST_SAVE,  2'b10, 32'd254);
    step("mr_f1",    0, 0, 0, 0, ST_FETCH, 2'b10, 32'd254);
    step("mr_f2",    0, 0, 0, 0, ST_FETCH, 2'b10, 32'd254);
    step("mr_rst",   1, 0, 0, 0, ST_IDLE,  2'b00, 32'd0);
    step("mr_idle",  0, 0, 0, 0, ST_IDLE,  2'b00, 32'd0);
    step("mr_idle2", 0, 0, 0, 0, ST_IDLE,  2'b00, 32'd0);

    // 6: overflow held across exc_done restarts after one idle cycle
    step("hd_save",  0, 0, 1, 0, ST_SAVE,  2'b10, 32'd254);
    step("hd_f1",    0, 0, 1, 0, ST_FETCH, 2'b10, 32'd254);
    step("hd_f2",    0, 0, 1, 0, ST_FETCH, 2'b10, 32'd254);
    step("hd_load",  0, 0, 1, 0, ST_LOAD,  2'b10, 32'd254);
    step("hd_done",  0, 0, 1, 0, ST_DONE,  2'b10, 32'd254);
    step("hd_idle",  0, 0, 1, 0, ST_IDLE,  2'b10, 32'd254);
    step("hd_save2", 0, 0, 1, 0, ST_SAVE,  2'b10, 32'd254);
    step("hd_f1b",   0, 0, 0, 0, ST_FETCH, 2'b10, 32'd254);
    step("hd_f2b",   0, 0, 0, 0, ST_FETCH, 2'b10, 32'd254);
    step("hd_loadb", 0, 0, 0, 0, ST_LOAD,  2'b10, 32'd254);
    step("hd_doneb", 0, 0, 0, 0, ST_DONE,  2'b10, 32'd254);
    step("hd_idleb", 0, 0, 0, 0, ST_IDLE,  2'b10, 32'd254);

    repeat (3) @(posedge clk);
    #2;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of run, want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
